// File: rtl/branch_resolve_pkg.sv
// Shared processor definitions for execute-stage control-flow resolution:
// opcode constants, resolver FSM state encoding and small decode helpers.
package branch_resolve_pkg;

    localparam logic [4:0] OP_J   = 5'b00001;
    localparam logic [4:0] OP_BNE = 5'b00010;
    localparam logic [4:0] OP_JAL = 5'b00011;
    localparam logic [4:0] OP_JR  = 5'b00100;
    localparam logic [4:0] OP_BLT = 5'b00110;
    localparam logic [4:0] OP_BEX = 5'b10110;

    localparam logic [31:0] PC_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_REDIRECT = 2'b01,
        ST_SQUASH   = 2'b10
    } br_state_e;

    // How the target of a control instruction is formed.
    typedef enum logic [1:0] {
        TGT_NONE = 2'b00,
        TGT_REL  = 2'b01,
        TGT_ABS  = 2'b10,
        TGT_REG  = 2'b11
    } tgt_kind_e;

    function automatic logic is_control(input logic [4:0] op);
        logic result;
        case (op)
            OP_J, OP_BNE, OP_JAL, OP_JR, OP_BLT, OP_BEX: result = 1'b1;
            default:                                     result = 1'b0;
        endcase
        return result;
    endfunction

    function automatic tgt_kind_e target_kind(input logic [4:0] op);
        tgt_kind_e kind;
        case (op)
            OP_BNE, OP_BLT:       kind = TGT_REL;
            OP_J, OP_JAL, OP_BEX: kind = TGT_ABS;
            OP_JR:                kind = TGT_REG;
            default:              kind = TGT_NONE;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational condition and target evaluation for the execute-stage
// instruction; pure function of its inputs, no state.
module branch_cond
    import branch_resolve_pkg::*;
(
    input  logic [4:0]  opcode,
    input  logic [31:0] pc_plus1,
    input  logic [31:0] imm,
    input  logic [26:0] target,
    input  logic [31:0] rd_val,
    input  logic        is_less_than,
    input  logic        is_not_equal,
    input  logic        rstatus_nonzero,
    output logic        is_ctrl,
    output logic        taken,
    output logic [31:0] target_pc
);

    tgt_kind_e kind_s;

    assign kind_s = target_kind(opcode);

    // Decide whether the instruction is a control transfer and whether it is taken.
    always_comb begin
        is_ctrl = is_control(opcode);
        taken   = 1'b0;
        case (opcode)
            OP_J, OP_JAL, OP_JR: taken = 1'b1;
            OP_BNE:              taken = is_not_equal;
            OP_BLT:              taken = is_not_equal & ~is_less_than;
            OP_BEX:              taken = rstatus_nonzero;
            default:             taken = 1'b0;
        endcase
    end

    // Relative targets wrap modulo 2^32 by plain 32-bit addition.
    always_comb begin
        target_pc = PC_ZERO;
        case (kind_s)
            TGT_REL:  target_pc = pc_plus1 + imm;
            TGT_ABS:  target_pc = {5'b00000, target};
            TGT_REG:  target_pc = rd_val;
            TGT_NONE: target_pc = PC_ZERO;
            default:  target_pc = PC_ZERO;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolver: redirects fetch on taken control transfers,
// squashes the two younger pipeline latches and keeps saturating statistics.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             dx_valid,
    input  logic [4:0]       dx_opcode,
    input  logic [31:0]      dx_pc_plus1,
    input  logic [31:0]      dx_imm,
    input  logic [26:0]      dx_target,
    input  logic [31:0]      dx_rd_val,
    input  logic             alu_isLessThan,
    input  logic             alu_isNotEqual,
    input  logic             rstatus_nonzero,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             flush_fd,
    output logic             flush_dx,
    output logic [CNT_W-1:0] resolved_count,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    br_state_e        state_r;
    logic             is_ctrl_s;
    logic             taken_s;
    logic [31:0]      target_s;
    logic             accept_s;
    logic [CNT_W-1:0] resolved_inc_s;
    logic [CNT_W-1:0] taken_inc_s;

    branch_cond u_cond (
        .opcode          (dx_opcode),
        .pc_plus1        (dx_pc_plus1),
        .imm             (dx_imm),
        .target          (dx_target),
        .rd_val          (dx_rd_val),
        .is_less_than    (alu_isLessThan),
        .is_not_equal    (alu_isNotEqual),
        .rstatus_nonzero (rstatus_nonzero),
        .is_ctrl         (is_ctrl_s),
        .taken           (taken_s),
        .target_pc       (target_s)
    );

    // Wrong-path instructions behind a redirect are never accepted.
    assign accept_s = dx_valid & is_ctrl_s & ~stall & (state_r == ST_IDLE);

    // Saturating increment values for both statistics counters.
    always_comb begin
        if (resolved_count == CNT_MAX) begin
            resolved_inc_s = CNT_MAX;
        end else begin
            resolved_inc_s = resolved_count + CNT_ONE;
        end
        if (taken_count == CNT_MAX) begin
            taken_inc_s = CNT_MAX;
        end else begin
            taken_inc_s = taken_count + CNT_ONE;
        end
    end

    // Resolver FSM and counters; outputs are registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            redirect       <= 1'b0;
            redirect_pc    <= PC_ZERO;
            flush_fd       <= 1'b0;
            flush_dx       <= 1'b0;
            resolved_count <= CNT_ZERO;
            taken_count    <= CNT_ZERO;
        end else if (!stall) begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        resolved_count <= resolved_inc_s;
                        if (taken_s) begin
                            taken_count <= taken_inc_s;
                            state_r     <= ST_REDIRECT;
                            redirect    <= 1'b1;
                            redirect_pc <= target_s;
                            flush_fd    <= 1'b1;
                            flush_dx    <= 1'b1;
                        end
                    end
                end
                ST_REDIRECT: begin
                    state_r     <= ST_SQUASH;
                    redirect    <= 1'b0;
                    redirect_pc <= PC_ZERO;
                    flush_fd    <= 1'b0;
                    flush_dx    <= 1'b1;
                end
                ST_SQUASH: begin
                    state_r     <= ST_IDLE;
                    redirect    <= 1'b0;
                    redirect_pc <= PC_ZERO;
                    flush_fd    <= 1'b0;
                    flush_dx    <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    redirect    <= 1'b0;
                    redirect_pc <= PC_ZERO;
                    flush_fd    <= 1'b0;
                    flush_dx    <= 1'b0;
                end
            endcase
        end
    end

endmodule
